// File: rtl/stage_ex_mc_pkg.sv
// rtl/stage_ex_mc_pkg.sv - shared op codes, operand-source codes and FSM states for the execute stage
package stage_ex_mc_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_XOR = 4'd4;
  localparam logic [3:0] ALU_OP_SLT = 4'd5;
  localparam logic [3:0] ALU_OP_SLL = 4'd6;
  localparam logic [3:0] ALU_OP_SRL = 4'd7;
  localparam logic [3:0] ALU_OP_MUL = 4'd8;

  localparam int ALU_SRC_W = 1;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_REG = 1'b0;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_RUN  = 2'd1,
    ST_MUL_DONE = 2'd2
  } ex_state_e;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - radix-2 shift-add multiplier, one multiplier bit per cycle, low DATA_W product bits
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              hold,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              running;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (!hold) begin
      if (start) begin
        a_sh    <= a;
        b_sh    <= b;
        acc     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (b_sh[0]) begin
          acc <= acc + a_sh;
        end
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          running <= 1'b0;
        end
      end
    end
  end

  // Pulses during the final iteration so the owner can advance on the same edge.
  assign done    = running && !hold && (cnt == CNT_LAST);
  assign product = acc;

endmodule

// File: rtl/stage_ex_mc.sv
// rtl/stage_ex_mc.sv - execute stage: forwarding operand select, single-cycle ALU, iterative MUL
module stage_ex_mc
  import stage_ex_mc_pkg::*;
#(
  parameter int DATA_W             = 32,
  parameter int REG_ADDR_W         = 5,
  parameter bit ZERO_REG_FWD_BLOCK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  reg_wr,
  input  logic [REG_ADDR_W-1:0] reg_addr_rd,
  input  logic [REG_ADDR_W-1:0] reg_addr_r1,
  input  logic [REG_ADDR_W-1:0] reg_addr_r2,
  input  logic [3:0]            alu_op,
  input  logic [ALU_SRC_W-1:0]  alu_src_arg1,
  input  logic [ALU_SRC_W-1:0]  alu_src_arg2,
  input  logic [DATA_W-1:0]     imm,
  input  logic [DATA_W-1:0]     reg_data_r1,
  input  logic [DATA_W-1:0]     reg_data_r2,
  input  logic                  ffw_EX_reg_wr,
  input  logic [REG_ADDR_W-1:0] ffw_EX_reg_addr_rd,
  input  logic [DATA_W-1:0]     ffw_EX_reg_data_rd,
  input  logic                  ffw_MM_reg_wr,
  input  logic [REG_ADDR_W-1:0] ffw_MM_reg_addr_rd,
  input  logic [DATA_W-1:0]     ffw_MM_reg_data_rd,
  output logic                  out_reg_wr,
  output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
  output logic [DATA_W-1:0]     out_alu_res,
  output logic                  out_flush,
  output logic                  out_busy
);

  localparam int SH_W = $clog2(DATA_W);

  ex_state_e             state;
  ex_state_e             state_nx;
  logic [DATA_W-1:0]     arg1;
  logic [DATA_W-1:0]     arg2;
  logic [DATA_W-1:0]     alu_res;
  logic [DATA_W-1:0]     mul_product;
  logic                  mul_start;
  logic                  mul_done;
  logic                  mul_wr;
  logic [REG_ADDR_W-1:0] mul_rd;
  logic                  issue;
  logic                  is_mul;

  // EX beats MM; a zero-register match never forwards when blocking is enabled.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [ALU_SRC_W-1:0]  src,
    input logic [REG_ADDR_W-1:0] r,
    input logic [DATA_W-1:0]     rf_data,
    input logic [DATA_W-1:0]     imm_v,
    input logic                  ex_wr,
    input logic [REG_ADDR_W-1:0] ex_addr,
    input logic [DATA_W-1:0]     ex_data,
    input logic                  mm_wr,
    input logic [REG_ADDR_W-1:0] mm_addr,
    input logic [DATA_W-1:0]     mm_data
  );
    logic blocked;
    blocked = ZERO_REG_FWD_BLOCK && (r == '0);
    if (src == ALU_SRC_IMM)                          return imm_v;
    else if (ex_wr && (ex_addr == r) && !blocked)    return ex_data;
    else if (mm_wr && (mm_addr == r) && !blocked)    return mm_data;
    else                                             return rf_data;
  endfunction

  assign arg1 = pick_operand(alu_src_arg1, reg_addr_r1, reg_data_r1, imm,
                             ffw_EX_reg_wr, ffw_EX_reg_addr_rd, ffw_EX_reg_data_rd,
                             ffw_MM_reg_wr, ffw_MM_reg_addr_rd, ffw_MM_reg_data_rd);
  assign arg2 = pick_operand(alu_src_arg2, reg_addr_r2, reg_data_r2, imm,
                             ffw_EX_reg_wr, ffw_EX_reg_addr_rd, ffw_EX_reg_data_rd,
                             ffw_MM_reg_wr, ffw_MM_reg_addr_rd, ffw_MM_reg_data_rd);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_OP_ADD: alu_res = arg1 + arg2;
      ALU_OP_SUB: alu_res = arg1 - arg2;
      ALU_OP_AND: alu_res = arg1 & arg2;
      ALU_OP_OR:  alu_res = arg1 | arg2;
      ALU_OP_XOR: alu_res = arg1 ^ arg2;
      ALU_OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(arg1) < $signed(arg2))};
      ALU_OP_SLL: alu_res = arg1 << arg2[SH_W-1:0];
      ALU_OP_SRL: alu_res = arg1 >> arg2[SH_W-1:0];
      default:    alu_res = '0;
    endcase
  end

  assign out_busy  = (state != ST_IDLE);
  assign is_mul    = (alu_op == ALU_OP_MUL);
  assign issue     = en && !stall && !out_busy && (state == ST_IDLE);
  assign mul_start = issue && !flush && is_mul;

  mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (arg1),
    .b       (arg2),
    .hold    (!en),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (en) begin
      case (state)
        ST_IDLE:     if (mul_start) state_nx = ST_MUL_RUN;
        ST_MUL_RUN:  if (mul_done)  state_nx = ST_MUL_DONE;
        ST_MUL_DONE: if (!stall)    state_nx = ST_IDLE;
        default:                    state_nx = ST_IDLE;
      endcase
    end
  end

  // Output pipeline register; bubbles keep rd/result but never write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg_wr      <= 1'b0;
      out_reg_addr_rd <= '0;
      out_alu_res     <= '0;
      out_flush       <= 1'b1;
      mul_rd          <= '0;
      mul_wr          <= 1'b0;
    end else if (en && !stall) begin
      case (state)
        ST_IDLE: begin
          if (flush || is_mul) begin
            out_flush  <= 1'b1;
            out_reg_wr <= 1'b0;
            if (!flush) begin
              mul_rd <= reg_addr_rd;
              mul_wr <= reg_wr;
            end
          end else begin
            out_flush       <= 1'b0;
            out_reg_wr      <= reg_wr;
            out_reg_addr_rd <= reg_addr_rd;
            out_alu_res     <= alu_res;
          end
        end
        ST_MUL_DONE: begin
          out_flush       <= 1'b0;
          out_reg_wr      <= mul_wr;
          out_reg_addr_rd <= mul_rd;
          out_alu_res     <= mul_product;
        end
        default: begin
          out_flush  <= 1'b1;
          out_reg_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ex_mc.sv
// tb/tb_stage_ex_mc.sv - self-checking bench for stage_ex_mc
module tb_stage_ex_mc;
  import stage_ex_mc_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n, en, stall, flush, reg_wr;
  logic [AW-1:0] rd, r1, r2;
  logic [3:0]    op;
  logic [0:0]    src1, src2;
  logic [DW-1:0] imm, d1, d2;
  logic          exwr, mmwr;
  logic [AW-1:0] exa, mma;
  logic [DW-1:0] exd, mmd;
  logic          o_wr, o_flush, o_busy;
  logic [AW-1:0] o_rd;
  logic [DW-1:0] o_res;

  int vectors = 0;
  int miscompares = 0;

  stage_ex_mc #(.DATA_W(DW), .REG_ADDR_W(AW), .ZERO_REG_FWD_BLOCK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush), .reg_wr(reg_wr),
    .reg_addr_rd(rd), .reg_addr_r1(r1), .reg_addr_r2(r2), .alu_op(op),
    .alu_src_arg1(src1), .alu_src_arg2(src2), .imm(imm),
    .reg_data_r1(d1), .reg_data_r2(d2),
    .ffw_EX_reg_wr(exwr), .ffw_EX_reg_addr_rd(exa), .ffw_EX_reg_data_rd(exd),
    .ffw_MM_reg_wr(mmwr), .ffw_MM_reg_addr_rd(mma), .ffw_MM_reg_data_rd(mmd),
    .out_reg_wr(o_wr), .out_reg_addr_rd(o_rd), .out_alu_res(o_res),
    .out_flush(o_flush), .out_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [0:0]    s1, s2;
    logic [AW-1:0] r1, r2;
    logic [DW-1:0] imm, d1, d2;
    logic          exwr;
    logic [AW-1:0] exa;
    logic [DW-1:0] exd;
    logic          mmwr;
    logic [AW-1:0] mma;
    logic [DW-1:0] mmd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    en = 1'b1; stall = 1'b0; flush = 1'b1; reg_wr = 1'b0;
    rd = '0; r1 = '0; r2 = '0; op = ALU_OP_ADD;
    src1 = ALU_SRC_REG; src2 = ALU_SRC_REG; imm = '0; d1 = '0; d2 = '0;
    exwr = 1'b0; exa = '0; exd = '0; mmwr = 1'b0; mma = '0; mmd = '0;
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic s1, input logic s2,
                              input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [DW-1:0] im, input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                              input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                              input logic mw, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                              input logic [DW-1:0] e);
    vec_t v;
    v.op = o; v.s1 = s1; v.s2 = s2; v.r1 = a1; v.r2 = a2; v.imm = im; v.d1 = v1; v.d2 = v2;
    v.exwr = ew; v.exa = ea; v.exd = ed; v.mmwr = mw; v.mma = ma; v.mmd = md; v.exp = e;
    return v;
  endfunction

  // Reference: operand rules and op semantics from the stage description.
  function automatic logic [DW-1:0] model_arg(input logic s, input logic [AW-1:0] r, input logic [DW-1:0] rf,
                                              input logic [DW-1:0] im, input logic ew, input logic [AW-1:0] ea,
                                              input logic [DW-1:0] ed, input logic mw, input logic [AW-1:0] ma,
                                              input logic [DW-1:0] md);
    if (s) return im;
    if (r != 0 && ew && ea == r) return ed;
    if (r != 0 && mw && ma == r) return md;
    return rf;
  endfunction

  function automatic logic [DW-1:0] model_alu(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return a << (b % 32);
      4'd7: return a >> (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  task automatic mul_seq(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] dst,
                         input int stall_from, input int stall_len, input int exp_busy);
    logic [63:0]   full;
    logic [DW-1:0] exp;
    int n, k;
    full = 64'(a) * 64'(b);
    exp  = full[31:0];
    quiet_inputs();
    op = ALU_OP_MUL; flush = 1'b0; reg_wr = 1'b1; rd = dst;
    r1 = 5'd1; r2 = 5'd2; d1 = a; d2 = b;
    tick();
    chkb("mul_issue_bubble_wr", o_wr, 1'b0);
    chkb("mul_issue_bubble_flush", o_flush, 1'b1);
    n = o_busy ? 1 : 0;
    k = 1;
    while (o_busy && n < 200) begin
      stall = (k >= stall_from && k < stall_from + stall_len);
      tick();
      k++;
      if (o_busy) begin
        n++;
        if (o_wr) chkb("mul_inflight_wr", o_wr, 1'b0);
      end
    end
    stall = 1'b0; flush = 1'b1; op = ALU_OP_ADD;
    chk("mul_busy_cycles", DW'(n), DW'(exp_busy));
    chk("mul_result", o_res, exp);
    chk("mul_rd", DW'(o_rd), DW'(dst));
    chkb("mul_wr", o_wr, 1'b1);
    chkb("mul_flush", o_flush, 1'b0);
    tick();
    chkb("mul_no_dup_write", o_wr, 1'b0);
    chkb("mul_idle_busy", o_busy, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] m_res, a_v, b_v;
    logic          m_wr, m_flush;
    logic [AW-1:0] m_rd;
    int            r;

    quiet_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chkb("rst_flush", o_flush, 1'b1);
    chkb("rst_wr", o_wr, 1'b0);
    chkb("rst_busy", o_busy, 1'b0);
    chk("rst_res", o_res, 32'h0);
    rst_n = 1'b1;
    tick();
    chkb("idle_busy", o_busy, 1'b0);

    tbl.push_back(mk(ALU_OP_ADD, 0, 1, 3, 0, 1, 32'h99, 0, 1, 3, 32'h11, 1, 3, 32'h22, 32'h12));
    tbl.push_back(mk(ALU_OP_ADD, 0, 1, 3, 0, 1, 32'h99, 0, 0, 3, 32'h11, 1, 3, 32'h22, 32'h23));
    tbl.push_back(mk(ALU_OP_ADD, 0, 1, 0, 0, 1, 32'h40, 0, 1, 0, 32'h11, 1, 0, 32'h22, 32'h41));
    tbl.push_back(mk(ALU_OP_SLT, 0, 1, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 32'h1));
    tbl.push_back(mk(ALU_OP_SLT, 0, 1, 1, 0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(ALU_OP_SLL, 0, 1, 1, 0, 33, 32'h1, 0, 0, 0, 0, 0, 0, 0, 32'h2));
    tbl.push_back(mk(ALU_OP_SRL, 0, 1, 1, 0, 4, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0800_0000));
    tbl.push_back(mk(ALU_OP_SUB, 0, 1, 1, 0, 3, 32'h2, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(ALU_OP_AND, 0, 0, 1, 4, 0, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 0, 32'hF000));
    tbl.push_back(mk(ALU_OP_OR,  0, 0, 1, 4, 0, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 0, 32'hFFF0));
    tbl.push_back(mk(ALU_OP_XOR, 0, 0, 1, 4, 0, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 0, 32'h0FF0));
    tbl.push_back(mk(4'hF,       0, 1, 1, 0, 7, 32'h5, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(ALU_OP_ADD, 1, 0, 0, 6, 1, 0, 32'h5, 1, 5, 32'h7, 1, 6, 32'h100, 32'h101));
    tbl.push_back(mk(ALU_OP_ADD, 1, 1, 2, 2, 32'h7FFF_FFFF, 0, 0, 1, 2, 32'h3, 1, 2, 32'h4, 32'hFFFF_FFFE));

    foreach (tbl[i]) begin
      quiet_inputs();
      flush = 1'b0; reg_wr = 1'b1; rd = 5'd9;
      op = tbl[i].op; src1 = tbl[i].s1; src2 = tbl[i].s2; r1 = tbl[i].r1; r2 = tbl[i].r2;
      imm = tbl[i].imm; d1 = tbl[i].d1; d2 = tbl[i].d2;
      exwr = tbl[i].exwr; exa = tbl[i].exa; exd = tbl[i].exd;
      mmwr = tbl[i].mmwr; mma = tbl[i].mma; mmd = tbl[i].mmd;
      tick();
      chk($sformatf("tbl%0d_res", i), o_res, tbl[i].exp);
      chkb($sformatf("tbl%0d_wr", i), o_wr, 1'b1);
      chk($sformatf("tbl%0d_rd", i), DW'(o_rd), DW'(9));
      chkb($sformatf("tbl%0d_flush", i), o_flush, 1'b0);
    end

    m_res = tbl[tbl.size()-1].exp; m_wr = 1'b1; m_rd = 5'd9; m_flush = 1'b0;
    for (int i = 0; i < 300; i++) begin
      r      = int'($urandom_range(0, 15));
      en     = ($urandom_range(0, 7) != 0);
      stall  = ($urandom_range(0, 7) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      op     = 4'(r);
      if (op == ALU_OP_MUL && !flush) op = ALU_OP_ADD;
      reg_wr = 1'($urandom_range(0, 1));
      rd     = AW'($urandom_range(0, 31));
      r1     = AW'($urandom_range(0, 3)); r2 = AW'($urandom_range(0, 3));
      exa    = AW'($urandom_range(0, 3)); mma = AW'($urandom_range(0, 3));
      exwr   = 1'($urandom_range(0, 1)); mmwr = 1'($urandom_range(0, 1));
      src1   = 1'($urandom_range(0, 1)); src2 = 1'($urandom_range(0, 1));
      imm    = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 63)) : $urandom;
      d1 = $urandom; d2 = $urandom; exd = $urandom; mmd = $urandom;
      if (en && !stall) begin
        if (flush) begin
          m_flush = 1'b1; m_wr = 1'b0;
        end else begin
          a_v = model_arg(src1, r1, d1, imm, exwr, exa, exd, mmwr, mma, mmd);
          b_v = model_arg(src2, r2, d2, imm, exwr, exa, exd, mmwr, mma, mmd);
          m_res = model_alu(op, a_v, b_v); m_wr = reg_wr; m_rd = rd; m_flush = 1'b0;
        end
      end
      tick();
      chk($sformatf("rnd%0d_res", i), o_res, m_res);
      chkb($sformatf("rnd%0d_wr", i), o_wr, m_wr);
      chk($sformatf("rnd%0d_rd", i), DW'(o_rd), DW'(m_rd));
      chkb($sformatf("rnd%0d_flush", i), o_flush, m_flush);
      chkb($sformatf("rnd%0d_busy", i), o_busy, 1'b0);
    end

    mul_seq(32'h0001_0003, 32'h0000_0005, 5'd7, -1, 0, 33);
    mul_seq(32'h0001_0003, 32'h0000_0005, 5'd7, 31, 4, 35);
    mul_seq($urandom, $urandom, 5'd12, 5, 3, 33);
    for (int i = 0; i < 3; i++) mul_seq($urandom, $urandom, AW'($urandom_range(1, 31)), -1, 0, 33);

    quiet_inputs();
    op = ALU_OP_MUL; flush = 1'b0; reg_wr = 1'b1; rd = 5'd3; d1 = 32'd7; d2 = 32'd9;
    tick();
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    chkb("rstmul_busy", o_busy, 1'b0);
    chkb("rstmul_wr", o_wr, 1'b0);
    chkb("rstmul_flush", o_flush, 1'b1);
    rst_n = 1'b1;
    quiet_inputs();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_wr || o_busy) chkb($sformatf("rstmul_quiet%0d", i), o_wr | o_busy, 1'b0);
    end
    chkb("rstmul_quiet_end", o_wr | o_busy, 1'b0);
    flush = 1'b0; reg_wr = 1'b1; rd = 5'd4; op = ALU_OP_ADD;
    src1 = ALU_SRC_REG; d1 = 32'd2; src2 = ALU_SRC_IMM; imm = 32'd3;
    tick();
    chk("after_rst_add", o_res, 32'd5);
    chkb("after_rst_add_wr", o_wr, 1'b1);

    en = 1'b0; d1 = 32'd100;
    tick();
    chk("en0_hold_res", o_res, 32'd5);
    chkb("en0_hold_wr", o_wr, 1'b1);
    en = 1'b1;

    op = ALU_OP_MUL; flush = 1'b1;
    tick();
    chkb("flushmul_busy", o_busy, 1'b0);
    chkb("flushmul_flush", o_flush, 1'b1);
    chkb("flushmul_wr", o_wr, 1'b0);
    op = ALU_OP_ADD;
    tick();
    chkb("flushmul_busy2", o_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
